keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_N, default 16, column-dwell counter width; dwell is 2^SCAN_N clk cycles, about 1.5 kHz per column at 100 MHz.
REQ-002 Parameter DB_SCANS, default 4, consecutive identical full-scan results required to accept a press or a release; legal range 1..15.
REQ-003 clk  input  1  single system clock; all logic is on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 col  output  4  active-low column drive; exactly one bit is low at any time.
REQ-006 row  input  4  active-low row sense, asynchronous to clk; external pull-ups.
REQ-007 key_code  output  4  code of the accepted key, {row_idx[1:0], col_idx[1:0]}.
REQ-008 key_valid  output  1  one-cycle pulse when a press is accepted.
REQ-009 key_held  output  1  level; high while the accepted key is considered held.

Function
REQ-010 row SHALL pass through a 2-flop synchronizer before any use; the second stage is row_s.
REQ-011 Dwell counter SHALL increment every cycle and wrap from 2^SCAN_N-1 to 0; tc is high when the count is 2^SCAN_N-1.
REQ-012 A 2-bit column index SHALL advance on tc and wrap from 3 to 0; col = ~(4'b0001 << index), registered.
REQ-013 row_s SHALL be sampled only on tc (last dwell cycle), so the column has settled; sampling at any other time is forbidden.
REQ-014 Per-scan accumulator SHALL record the count of low row_s bits (saturating at 2) and the code of the last pressed bit found (lowest row index wins within a column).
REQ-015 On tc with index==3, the scan result SHALL be NONE (count 0), SINGLE(code) (count 1), or MULTI (count >=2); the accumulator then clears for the next scan.
REQ-016 Debounce FSM states: IDLE, DB_PRESS, PRESSED, DB_REL; it is evaluated only on scan-result cycles.
REQ-017 IDLE: SINGLE(c) latches cand=c, sets match=1; goes to PRESSED if DB_SCANS==1, else to DB_PRESS. NONE or MULTI stays in IDLE.
REQ-018 DB_PRESS: SINGLE(cand) increments match; when match reaches DB_SCANS, go to PRESSED. SINGLE(other) reloads cand and sets match=1. NONE or MULTI returns to IDLE.
REQ-019 On entry to PRESSED: key_code<=cand; key_valid high for exactly the next clk cycle; key_held<=1.
REQ-020 PRESSED: SINGLE(cand) stays. Any other result goes to DB_REL with rel=1, or straight to IDLE if DB_SCANS==1.
REQ-021 DB_REL: SINGLE(cand) returns to PRESSED with no new key_valid. Any other result increments rel; at rel==DB_SCANS go to IDLE and clear key_held.
REQ-022 key_code SHALL hold its last accepted value after release.
REQ-023 Press latency: key_valid rises one cycle after the scan-result cycle of the DB_SCANS-th consecutive SINGLE(c).
REQ-024 MULTI never produces key_valid; in PRESSED/DB_REL it counts as not-held.

Reset
REQ-025 reset low SHALL immediately force: col=4'b1110, key_code=0, key_valid=0, key_held=0, all counters and synchronizer flops 0, FSM=IDLE.
REQ-026 Assertion mid-scan or mid-debounce SHALL discard all partial results; after release, scanning restarts at column 0 with a count of 0.

Verification (SCAN_N=2, DB_SCANS=2: 4 cycles/column, 16 cycles/scan)
REQ-027 Reset, no keys: col cycles 1110,1101,1011,0111, changing every 4 cycles; key_valid and key_held stay 0 for 10 scans.
REQ-028 Hold key row2/col1 steadily: exactly one key_valid pulse, key_code=4'h9, one cycle after the second full scan's result; key_held stays high while held and falls 1 cycle after the 2nd NONE scan following release.
REQ-029 Bounce: key 4'h9 present one scan, absent one scan, present two scans: a single key_valid after the final two scans, never earlier.
REQ-030 Press keys 4'h2 and 4'h7 simultaneously for 5 scans: no key_valid. Then release 4'h7: key_valid with key_code=4'h2 after 2 scans.
REQ-031 Assert reset mid-DB_PRESS after one matching scan, then release: outputs equal the REQ-025 values; acceptance requires 2 fresh full scans.
REQ-032 Held key 4'hF drops for exactly one scan: no new key_valid and key_held stays 1.

Source files
------------

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with full-scan debounce.
// Revision 1.0 - initial release.
`default_nettype none

module keypad_scan #(
  parameter int SCAN_N   = 16,
  parameter int DB_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] col,
  input  logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [3:0] c_DB_SCANS = 4'(DB_SCANS);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DB_PRESS = 2'd1,
    S_PRESSED  = 2'd2,
    S_DB_REL   = 2'd3
  } state_t;

  logic [3:0]        r_row_meta;
  logic [3:0]        r_row_s;
  logic [SCAN_N-1:0] r_cnt;
  logic [1:0]        r_idx;
  logic [3:0]        r_col;
  logic [1:0]        r_acc_cnt;
  logic [3:0]        r_acc_code;
  state_t            r_state;
  logic [3:0]        r_cand;
  logic [3:0]        r_match;
  logic [3:0]        r_rel;
  logic [3:0]        r_key_code;
  logic              r_key_valid;
  logic              r_key_held;

  logic              w_tc;
  logic              w_res;
  logic [3:0]        w_low;
  logic [2:0]        w_col_cnt;
  logic [1:0]        w_row_idx;
  logic [2:0]        w_tot;
  logic [1:0]        w_sum_cnt;
  logic [3:0]        w_sum_code;
  logic              w_single;
  logic              w_hit;

  assign w_tc  = &r_cnt;
  assign w_res = w_tc && (r_idx == 2'd3);
  assign w_low = ~r_row_s;

  // Fold the current column into the running scan tally; lowest row wins in a column.
  always_comb begin
    w_col_cnt = 3'd0;
    w_row_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      w_col_cnt = w_col_cnt + {2'b00, w_low[i]};
    end
    for (int i = 3; i >= 0; i--) begin
      if (w_low[i]) w_row_idx = 2'(i);
    end
    w_tot      = {1'b0, r_acc_cnt} + w_col_cnt;
    w_sum_cnt  = (w_tot >= 3'd2) ? 2'd2 : w_tot[1:0];
    w_sum_code = (w_col_cnt != 3'd0) ? {w_row_idx, r_idx} : r_acc_code;
  end

  assign w_single = w_res && (w_sum_cnt == 2'd1);
  assign w_hit    = w_single && (w_sum_code == r_cand);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row_meta <= 4'd0;
      r_row_s    <= 4'd0;
      r_cnt      <= '0;
      r_idx      <= 2'd0;
      r_col      <= 4'b1110;
      r_acc_cnt  <= 2'd0;
      r_acc_code <= 4'd0;
    end else begin
      r_row_meta <= row;
      r_row_s    <= r_row_meta;
      r_cnt      <= r_cnt + SCAN_N'(1);
      if (w_tc) begin
        r_idx <= r_idx + 2'd1;
        r_col <= ~(4'b0001 << (r_idx + 2'd1));
        if (r_idx == 2'd3) begin
          r_acc_cnt  <= 2'd0;
          r_acc_code <= 4'd0;
        end else begin
          r_acc_cnt  <= w_sum_cnt;
          r_acc_code <= w_sum_code;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cand      <= 4'd0;
      r_match     <= 4'd0;
      r_rel       <= 4'd0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_res) begin
        case (r_state)
          S_IDLE: begin
            if (w_single) begin
              r_cand  <= w_sum_code;
              r_match <= 4'd1;
              if (c_DB_SCANS == 4'd1) begin
                r_state     <= S_PRESSED;
                r_key_code  <= w_sum_code;
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
              end else begin
                r_state <= S_DB_PRESS;
              end
            end
          end
          S_DB_PRESS: begin
            if (w_hit) begin
              r_match <= r_match + 4'd1;
              if (r_match + 4'd1 == c_DB_SCANS) begin
                r_state     <= S_PRESSED;
                r_key_code  <= r_cand;
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
              end
            end else if (w_single) begin
              r_cand  <= w_sum_code;
              r_match <= 4'd1;
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_PRESSED: begin
            if (!w_hit) begin
              if (c_DB_SCANS == 4'd1) begin
                r_state    <= S_IDLE;
                r_key_held <= 1'b0;
              end else begin
                r_state <= S_DB_REL;
                r_rel   <= 4'd1;
              end
            end
          end
          S_DB_REL: begin
            if (w_hit) begin
              r_state <= S_PRESSED;
            end else begin
              r_rel <= r_rel + 4'd1;
              if (r_rel + 4'd1 == c_DB_SCANS) begin
                r_state    <= S_IDLE;
                r_key_held <= 1'b0;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign col       = r_col;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: table-driven bench for keypad_scan with a behavioural 4x4 keypad.
`default_nettype none

module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = 16'h0000;

  int total = 0;
  int bad   = 0;
  int ph_ticks;
  int pulses;
  int last;

  typedef struct {
    logic [15:0] keys;
    int          scans;
    int          pulses;
    int          last;
    logic        held;
    logic [3:0]  code;
  } vec_t;

  vec_t vecs[25];

  keypad_scan #(.SCAN_N(2), .DB_SCANS(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .col      (col),
    .row      (row),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Key bit index equals its code {row, col}; a pressed key pulls its row low when its column is driven.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic phase_start();
    ph_ticks = 0;
    pulses   = 0;
    last     = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ph_ticks++;
    if (key_valid === 1'b1) begin
      pulses++;
      last = ph_ticks;
    end
  endtask

  function automatic logic [3:0] col_exp(input int t);
    logic [3:0] pat [4];
    pat[0] = 4'b1110;
    pat[1] = 4'b1101;
    pat[2] = 4'b1011;
    pat[3] = 4'b0111;
    return pat[(t / 4) % 4];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{16'h0000, 10, 0, -1, 1'b0, 4'h0};
    vecs[1]  = '{16'h0200,  2, 1, 32, 1'b1, 4'h9};
    vecs[2]  = '{16'h0200,  4, 0, -1, 1'b1, 4'h9};
    vecs[3]  = '{16'h0000,  1, 0, -1, 1'b1, 4'h9};
    vecs[4]  = '{16'h0000,  1, 0, -1, 1'b0, 4'h9};
    vecs[5]  = '{16'h0200,  1, 0, -1, 1'b0, 4'h9};
    vecs[6]  = '{16'h0000,  1, 0, -1, 1'b0, 4'h9};
    vecs[7]  = '{16'h0200,  1, 0, -1, 1'b0, 4'h9};
    vecs[8]  = '{16'h0200,  1, 1, 16, 1'b1, 4'h9};
    vecs[9]  = '{16'h0000,  2, 0, -1, 1'b0, 4'h9};
    vecs[10] = '{16'h0084,  5, 0, -1, 1'b0, 4'h9};
    vecs[11] = '{16'h0004,  2, 1, 32, 1'b1, 4'h2};
    vecs[12] = '{16'h0000,  2, 0, -1, 1'b0, 4'h2};
    vecs[13] = '{16'h8000,  2, 1, 32, 1'b1, 4'hF};
    vecs[14] = '{16'h0000,  1, 0, -1, 1'b1, 4'hF};
    vecs[15] = '{16'h8000,  3, 0, -1, 1'b1, 4'hF};
    vecs[16] = '{16'h0000,  2, 0, -1, 1'b0, 4'hF};
    vecs[17] = '{16'h0022,  3, 0, -1, 1'b0, 4'hF};
    vecs[18] = '{16'h8000,  2, 1, 32, 1'b1, 4'hF};
    vecs[19] = '{16'h0008,  2, 0, -1, 1'b0, 4'hF};
    vecs[20] = '{16'h0008,  2, 1, 32, 1'b1, 4'h3};
    vecs[21] = '{16'h0000,  2, 0, -1, 1'b0, 4'h3};
    vecs[22] = '{16'h0010,  1, 0, -1, 1'b0, 4'h3};
    vecs[23] = '{16'h0100,  1, 0, -1, 1'b0, 4'h3};
    vecs[24] = '{16'h0100,  1, 1, 16, 1'b1, 4'h8};

    // Power-on reset.
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_col", 32'(col), 32'h0E);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_held", 32'(key_held), 32'h0);
    @(negedge clk) reset = 1'b1;

    // Column rotation over one idle scan.
    phase_start();
    check("col_t0", 32'(col), 32'h0E);
    for (int t = 1; t <= 16; t++) begin
      tick();
      check($sformatf("col_t%0d", t), 32'(col), 32'(col_exp(t)));
    end

    for (int v = 0; v < 25; v++) begin
      keys = vecs[v].keys;
      phase_start();
      repeat (vecs[v].scans * 16) tick();
      check($sformatf("v%0d_pulses", v), 32'(pulses), 32'(vecs[v].pulses));
      check($sformatf("v%0d_last", v), 32'(last), 32'(vecs[v].last));
      check($sformatf("v%0d_held", v), 32'(key_held), 32'(vecs[v].held));
      check($sformatf("v%0d_code", v), 32'(key_code), 32'(vecs[v].code));
    end

    // Reset while one matching scan is pending in the debouncer.
    keys = 16'h0000;
    repeat (32) tick();
    keys = 16'h0200;
    repeat (16) tick();
    repeat (4) tick();
    reset = 1'b0;
    #1;
    check("mid_rst_col", 32'(col), 32'h0E);
    check("mid_rst_code", 32'(key_code), 32'h0);
    check("mid_rst_valid", 32'(key_valid), 32'h0);
    check("mid_rst_held", 32'(key_held), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    phase_start();
    repeat (3) tick();
    check("post_rst_col3", 32'(col), 32'h0E);
    tick();
    check("post_rst_col4", 32'(col), 32'h0D);
    repeat (12) tick();
    check("post_rst_scan1_pulses", 32'(pulses), 32'h0);
    check("post_rst_scan1_held", 32'(key_held), 32'h0);
    repeat (16) tick();
    check("post_rst_pulses", 32'(pulses), 32'h1);
    check("post_rst_last", 32'(last), 32'd32);
    check("post_rst_code", 32'(key_code), 32'h9);

    // Release timing: held drops right after the second empty scan result.
    keys = 16'h0000;
    phase_start();
    repeat (31) tick();
    check("rel_held_before", 32'(key_held), 32'h1);
    tick();
    check("rel_held_after", 32'(key_held), 32'h0);
    check("rel_code_kept", 32'(key_code), 32'h9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
